// File: rtl/alu_pkg.sv
// Shared types for the Mic-1 ALU command sequencer: opcodes, control word, FSM states.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package alu_pkg;

  // Opcodes 0..15 map straight onto ALU control words; 16 is the multi-cycle MUL.
  // Encodings 17..31 are deliberately left undefined and are treated as illegal.
  typedef enum logic [4:0] {
    OP_A     = 5'd0,
    OP_B     = 5'd1,
    OP_NOTA  = 5'd2,
    OP_NOTB  = 5'd3,
    OP_ADD   = 5'd4,
    OP_ADD1  = 5'd5,
    OP_INCA  = 5'd6,
    OP_INCB  = 5'd7,
    OP_SUBBA = 5'd8,
    OP_DECB  = 5'd9,
    OP_NEGA  = 5'd10,
    OP_AND   = 5'd11,
    OP_OR    = 5'd12,
    OP_ZERO  = 5'd13,
    OP_ONE   = 5'd14,
    OP_MONE  = 5'd15,
    OP_MUL   = 5'd16
  } op_e;

  // Field order matches the ALU pin order F0 F1 ENA ENB INVA INC (f0 is the MSB).
  typedef struct packed {
    logic f0;
    logic f1;
    logic ena;
    logic enb;
    logic inva;
    logic inc;
  } alu_ctrl_t;

  // AND of two disabled inputs: the ALU output is forced to 0.
  localparam alu_ctrl_t CTRL_IDLE = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MULT = 2'd2,
    RESP = 2'd3
  } state_e;

  // MUL returns the ADD word because every MUL iteration is one ALU addition.
  function automatic alu_ctrl_t op_to_ctrl(input op_e op);
    alu_ctrl_t c;
    c = CTRL_IDLE;
    case (op)
      OP_A:     c = alu_ctrl_t'(6'b011000);
      OP_B:     c = alu_ctrl_t'(6'b010100);
      OP_NOTA:  c = alu_ctrl_t'(6'b011010);
      OP_NOTB:  c = alu_ctrl_t'(6'b101100);
      OP_ADD:   c = alu_ctrl_t'(6'b111100);
      OP_ADD1:  c = alu_ctrl_t'(6'b111101);
      OP_INCA:  c = alu_ctrl_t'(6'b111001);
      OP_INCB:  c = alu_ctrl_t'(6'b110101);
      OP_SUBBA: c = alu_ctrl_t'(6'b111111);
      OP_DECB:  c = alu_ctrl_t'(6'b110110);
      OP_NEGA:  c = alu_ctrl_t'(6'b111011);
      OP_AND:   c = alu_ctrl_t'(6'b001100);
      OP_OR:    c = alu_ctrl_t'(6'b011100);
      OP_ZERO:  c = alu_ctrl_t'(6'b010000);
      OP_ONE:   c = alu_ctrl_t'(6'b010001);
      OP_MONE:  c = alu_ctrl_t'(6'b010010);
      OP_MUL:   c = alu_ctrl_t'(6'b111100);
      default:  c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Opcode decoder: op -> ALU control word plus legal / is_mul classification.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller qualifies the outputs with its own handshake.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  op_e       op,
  output alu_ctrl_t ctrl,
  output logic      legal,
  output logic      is_mul
);

  // Table lookup plus range classification; illegal opcodes decode to CTRL_IDLE.
  always_comb begin
    ctrl   = op_to_ctrl(op);
    is_mul = (op == OP_MUL);
    legal  = (op <= OP_MONE) || (op == OP_MUL);
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side controller for the Mic-1 ALU: issues registered control words and operands, returns FUNC/Ovflag.
// Latency: accept edge counts as 1; single op rsp_valid at edge 2, MUL at count+1, illegal/count=0 at edge 1.
// Backpressure: one command in flight; cmd_ready low until the response is taken, response held while !rsp_ready.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int N     = 16,
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [4:0]   cmd_op,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic         rsp_ovf,
  output logic         rsp_err,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         F0,
  output logic         F1,
  output logic         ENA,
  output logic         ENB,
  output logic         INVA,
  output logic         INC,
  input  logic [N-1:0] alu_func,
  input  logic         alu_ovf
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_e           state_q, state_d;
  logic             ready_en_q;
  alu_ctrl_t        ctrl_q, ctrl_d;
  // alu_a_q doubles as the MUL accumulator: it always holds the last partial sum.
  logic [N-1:0]     alu_a_q, alu_a_d;
  logic [N-1:0]     alu_b_q, alu_b_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic [N-1:0]     rsp_data_q, rsp_data_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_err_q, rsp_err_d;

  alu_ctrl_t        dec_ctrl;
  logic             dec_legal;
  logic             dec_is_mul;
  logic             cmd_fire;
  logic [CNT_W-1:0] mul_cnt;

  alu_ctrl_decode u_decode (
    .op     (op_e'(cmd_op)),
    .ctrl   (dec_ctrl),
    .legal  (dec_legal),
    .is_mul (dec_is_mul)
  );

  // cmd_ready stays low during reset and the edge that releases it.
  assign cmd_ready = (state_q == IDLE) && ready_en_q;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign mul_cnt   = cmd_a[CNT_W-1:0];

  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_err   = rsp_err_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign F0        = ctrl_q.f0;
  assign F1        = ctrl_q.f1;
  assign ENA       = ctrl_q.ena;
  assign ENB       = ctrl_q.enb;
  assign INVA      = ctrl_q.inva;
  assign INC       = ctrl_q.inc;

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-datapath values; every register holds unless its state updates it.
  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rem_d        = rem_q;
    ovf_sticky_d = ovf_sticky_q;
    rsp_data_d   = rsp_data_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (!dec_legal) begin
            rsp_data_d = '0;
            rsp_ovf_d  = 1'b0;
            rsp_err_d  = 1'b1;
            state_d    = RESP;
          end else if (dec_is_mul) begin
            rsp_err_d = 1'b0;
            if (mul_cnt == CNT_ZERO) begin
              rsp_data_d = '0;
              rsp_ovf_d  = 1'b0;
              state_d    = RESP;
            end else begin
              rem_d        = mul_cnt;
              ovf_sticky_d = 1'b0;
              ctrl_d       = dec_ctrl;
              alu_a_d      = '0;
              alu_b_d      = cmd_b;
              state_d      = MULT;
            end
          end else begin
            ctrl_d  = dec_ctrl;
            alu_a_d = cmd_a;
            alu_b_d = cmd_b;
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        rsp_data_d = alu_func;
        rsp_ovf_d  = alu_ovf;
        rsp_err_d  = 1'b0;
        ctrl_d     = CTRL_IDLE;
        state_d    = RESP;
      end

      MULT: begin
        ovf_sticky_d = ovf_sticky_q | alu_ovf;
        rem_d        = rem_q - CNT_ONE;
        if (rem_q == CNT_ONE) begin
          rsp_data_d = alu_func;
          rsp_ovf_d  = ovf_sticky_q | alu_ovf;
          rsp_err_d  = 1'b0;
          ctrl_d     = CTRL_IDLE;
          state_d    = RESP;
        end else begin
          alu_a_d = alu_func;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and response registers; reset forces the ALU into its AND-of-zero idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_en_q   <= 1'b0;
      ctrl_q       <= CTRL_IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rem_q        <= '0;
      ovf_sticky_q <= 1'b0;
      rsp_data_q   <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      ready_en_q   <= 1'b1;
      ctrl_q       <= ctrl_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rem_q        <= rem_d;
      ovf_sticky_q <= ovf_sticky_d;
      rsp_data_q   <= rsp_data_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural Mic-1 ALU in the loop.
// Latency: measured in edges from the accept edge (counted as 1) to rsp_valid high.
// Backpressure: exercised by holding rsp_ready low with a competing command pending.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rstn;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [4:0]   cmd_op;
  logic [N-1:0] cmd_a;
  logic [N-1:0] cmd_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_data;
  logic         rsp_ovf;
  logic         rsp_err;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic         F0, F1, ENA, ENB, INVA, INC;
  logic [N-1:0] alu_func;
  logic         alu_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.N(N), .CNT_W(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf),
    .rsp_err   (rsp_err),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .F0        (F0),
    .F1        (F1),
    .ENA       (ENA),
    .ENB       (ENB),
    .INVA      (INVA),
    .INC       (INC),
    .alu_func  (alu_func),
    .alu_ovf   (alu_ovf)
  );

  logic [5:0] ctrl_obs;
  assign ctrl_obs = {F0, F1, ENA, ENB, INVA, INC};

  // Mic-1 ALU: gate/invert A, gate B, then AND / OR / NOT B / A+B+INC; Ovflag is signed add overflow.
  logic [N-1:0] m_a, m_b, m_sum;
  always_comb begin
    m_a = ENA ? alu_a : '0;
    if (INVA) m_a = ~m_a;
    m_b      = ENB ? alu_b : '0;
    m_sum    = m_a + m_b + {{(N-1){1'b0}}, INC};
    alu_func = '0;
    alu_ovf  = 1'b0;
    case ({F0, F1})
      2'b00: alu_func = m_a & m_b;
      2'b01: alu_func = m_a | m_b;
      2'b10: alu_func = ~m_b;
      default: begin
        alu_func = m_sum;
        alu_ovf  = (m_a[N-1] == m_b[N-1]) && (m_sum[N-1] != m_a[N-1]);
      end
    endcase
  end

  typedef struct {
    string      name;
    logic [4:0] op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] data;
    logic       ovf;
    logic       err;
    int         lat;
    logic [5:0] ctrl;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one command, measure latency, check the response, then complete the handshake.
  task automatic run_vec(input vec_t v);
    int w;
    int edges;
    logic [5:0] ctrl_first;
    @(negedge clk);
    cmd_op    = v.op;
    cmd_a     = v.a;
    cmd_b     = v.b;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({v.name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    cmd_op     = 5'd4;
    cmd_a      = 16'hDEAD;
    cmd_b      = 16'hBEEF;
    ctrl_first = ctrl_obs;
    edges      = 1;
    while (!rsp_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({v.name, "_ctrl"},      32'(ctrl_first), 32'(v.ctrl));
    check({v.name, "_latency"},   32'(edges),      32'(v.lat));
    check({v.name, "_rsp_valid"}, 32'(rsp_valid),  32'd1);
    check({v.name, "_data"},      32'(rsp_data),   32'(v.data));
    check({v.name, "_ovf"},       32'(rsp_ovf),    32'(v.ovf));
    check({v.name, "_err"},       32'(rsp_err),    32'(v.err));
    check({v.name, "_resp_ctrl"}, 32'(ctrl_obs),   32'd0);
    check({v.name, "_busy"},      32'(cmd_ready),  32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({v.name, "_rsp_drop"},  32'(rsp_valid),  32'd0);
    check({v.name, "_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int edges;
    int seen;
    logic [15:0] held;

    //               name          op     a         b         data      ovf   err   lat ctrl
    vecs[0]  = '{"add",        5'd4,  16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 2, 6'b111100};
    vecs[1]  = '{"subba",      5'd8,  16'h0001, 16'h0002, 16'h0001, 1'b0, 1'b0, 2, 6'b111111};
    vecs[2]  = '{"nega",       5'd10, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b0, 2, 6'b111011};
    vecs[3]  = '{"mone",       5'd15, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b0, 2, 6'b010010};
    vecs[4]  = '{"and",        5'd11, 16'h00F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 2, 6'b001100};
    vecs[5]  = '{"add_ovf",    5'd4,  16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 2, 6'b111100};
    vecs[6]  = '{"pass_a",     5'd0,  16'h1234, 16'h5678, 16'h1234, 1'b0, 1'b0, 2, 6'b011000};
    vecs[7]  = '{"notb",       5'd3,  16'h1234, 16'h00FF, 16'hFF00, 1'b0, 1'b0, 2, 6'b101100};
    vecs[8]  = '{"inca",       5'd6,  16'h0005, 16'h0009, 16'h0006, 1'b0, 1'b0, 2, 6'b111001};
    vecs[9]  = '{"decb",       5'd9,  16'h0009, 16'h0005, 16'h0004, 1'b0, 1'b0, 2, 6'b110110};
    vecs[10] = '{"zero",       5'd13, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 2, 6'b010000};
    vecs[11] = '{"mul_3x5",    5'd16, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 4, 6'b111100};
    vecs[12] = '{"mul_0",      5'd16, 16'h0000, 16'h0005, 16'h0000, 1'b0, 1'b0, 1, 6'b000000};
    vecs[13] = '{"mul_ovf",    5'd16, 16'h0002, 16'h7FFF, 16'hFFFE, 1'b1, 1'b0, 3, 6'b111100};
    vecs[14] = '{"mul_sticky", 5'd16, 16'h0003, 16'h7FFF, 16'h7FFD, 1'b1, 1'b0, 4, 6'b111100};
    vecs[15] = '{"mul_cntmask", 5'd16, 16'h0013, 16'h0007, 16'h0015, 1'b0, 1'b0, 4, 6'b111100};
    vecs[16] = '{"illegal20",  5'd20, 16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b1, 1, 6'b000000};
    vecs[17] = '{"illegal31",  5'd31, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1, 6'b000000};

    rstn      = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data",  32'(rsp_data),  32'd0);
    check("reset_rsp_flags", 32'({rsp_ovf, rsp_err}), 32'd0);
    check("reset_alu_ab",    32'({alu_a, alu_b}), 32'd0);
    check("reset_ctrl",      32'(ctrl_obs), 32'd0);

    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("first_cycle_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 18; i++) begin
      run_vec(vecs[i]);
    end

    // Backpressure: response held for 5 cycles while a second command waits.
    @(negedge clk);
    cmd_op = 5'd4; cmd_a = 16'h0010; cmd_b = 16'h0020; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_op = 5'd4; cmd_a = 16'h0100; cmd_b = 16'h0200;
    edges = 1;
    while (!rsp_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("bp_latency", 32'(edges), 32'd2);
    held = rsp_data;
    check("bp_data", 32'(held), 32'h30);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_data",  32'(rsp_data),  32'h30);
      check("bp_hold_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    check("bp_single_handshake", 32'(rsp_valid), 32'd0);

    // Reset in the middle of a long MUL aborts it without a response.
    @(negedge clk);
    cmd_op = 5'd16; cmd_a = 16'h000F; cmd_b = 16'h0003; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mulrst_busy_alu_b", 32'(alu_b), 32'h3);
    check("mulrst_busy_ctrl",  32'(ctrl_obs), 32'b111100);
    #2;
    rstn = 1'b0;
    #1;
    check("mulrst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("mulrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mulrst_rsp",       32'({rsp_data, rsp_ovf, rsp_err}), 32'd0);
    check("mulrst_alu_ab",    32'({alu_a, alu_b}), 32'd0);
    check("mulrst_ctrl",      32'(ctrl_obs), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("mulrst_idle_ready", 32'(cmd_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    check("mulrst_no_response", 32'(seen), 32'd0);

    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command-side controller for the N-bit Mic-1-style ALU: it generates the F0/F1/ENA/ENB/INVA/INC control word and the A/B operands that the ALU consumes.
- Accepts opcode and operand commands over a valid/ready handshake.
- Drives registered controls and operands into the ALU, captures FUNC and Ovflag, and returns them over a valid/ready response channel.
- Adds one multi-cycle op, MUL, implemented as repeated ALU additions.

Parameters:
N, 16, ALU datapath width
CNT_W, 4, width of the MUL iteration count, taken from cmd_a[CNT_W-1:0]

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  reset, asynchronous assert, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  5  opcode (alu_pkg::op_e)
cmd_a  in  N  operand A
cmd_b  in  N  operand B
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_data  out  N  captured result
rsp_ovf  out  1  captured overflow; sticky across MUL iterations
rsp_err  out  1  illegal opcode
alu_a  out  N  to ALU input A
alu_b  out  N  to ALU input B
F0, F1, ENA, ENB, INVA, INC  out  1 each  ALU control lines
alu_func  in  N  ALU result (FUNC)
alu_ovf  in  1  ALU overflow (Ovflag)

Behaviour:
- Reset (async, rstn=0): state IDLE; cmd_ready=0 while in reset; rsp_valid=0; rsp_data=0; rsp_ovf=0; rsp_err=0; alu_a=alu_b=0; all controls=0 (AND of disabled inputs, giving ALU output 0).
- First cycle after release: cmd_ready=1.
- Opcodes 0..15, as control word F0 F1 ENA ENB INVA INC:
  - A=011000, B=010100, NOTA=011010, NOTB=101100
  - ADD=111100, ADD1=111101, INCA=111001, INCB=110101
  - SUBBA=111111 (B-A), DECB=110110, NEGA=111011
  - AND=001100, OR=011100
  - ZERO=010000, ONE=010001, MONE=010010
- Opcode 16 is MUL. Opcodes 17..31 are illegal.
- cmd_ready=1 only in IDLE. A command is accepted when cmd_valid && cmd_ready.
- States:
  - IDLE:
    - Legal single op: register the control word, alu_a=cmd_a, alu_b=cmd_b; go to EXEC.
    - Illegal op: rsp_data=0, rsp_err=1, rsp_ovf=0; go to RESP, with no ALU cycle.
    - MUL with count=cmd_a[CNT_W-1:0]:
      - count=0: rsp_data=0, rsp_ovf=0; go to RESP.
      - otherwise: acc=0, remaining=count, controls=ADD, alu_a=0, alu_b=cmd_b; go to MULT.
  - EXEC (exactly 1 cycle): capture rsp_data=alu_func, rsp_ovf=alu_ovf, rsp_err=0; return controls to 0; go to RESP.
  - MULT: each cycle capture acc=alu_func and ovf_sticky|=alu_ovf, then decrement remaining.
    - If remaining becomes 0: rsp_data=alu_func, rsp_ovf=ovf_sticky|alu_ovf; controls to 0; go to RESP.
    - Else: alu_a=alu_func.
    - Result is B*count mod 2^N.
  - RESP: rsp_valid=1, and response fields are held stable until rsp_ready. On rsp_valid && rsp_ready go to IDLE and drop rsp_valid the next cycle.
- Latency, counted from the acceptance edge to the rsp_valid-high edge:
  - single op: 2 edges
  - MUL: count+1 edges
  - illegal opcode or count=0: 1 edge
- Throughput: at most one outstanding command. No command is accepted while in RESP; cmd_ready returns the cycle after the response handshake.
- cmd_* may change while not accepted and are ignored.
- Reset asserted mid-EXEC/MULT/RESP aborts immediately. No response is produced and all outputs return to reset values.
- alu_a, alu_b and the controls are registered (glitch-free), and change only on clk edges.

Decomposition:
- alu_pkg holds:
  - op_e enum (5 bits, values above)
  - alu_ctrl_t packed struct {f0,f1,ena,enb,inva,inc}
  - constant CTRL_IDLE (all 0)
  - function op_to_ctrl(op_e) returning alu_ctrl_t
  - state_e {IDLE, EXEC, MULT, RESP}
- Sub-module alu_ctrl_decode (combinational): op -> alu_ctrl_t plus legal and is_mul flags. It is reused by future microsequencers.

Test Plan:
- ADD: A=1, B=2 -> rsp_data=3, ovf=0, err=0; rsp_valid 2 edges after accept; controls=111100 during EXEC.
- SUBBA, NEGA, MONE with A=1, B=2 -> 1, 0xFFFF, 0xFFFF respectively; AND with A=0x00F0, B=0x0FF0 -> 0x00F0.
- Overflow: ADD with A=0x7FFF, B=1 -> rsp_data=0x8000, rsp_ovf=1.
- MUL: A=3, B=5 -> rsp_data=15, rsp_valid 4 edges after accept. MUL with A=0 -> 0 after 1 edge. MUL with A=2, B=0x7FFF -> 0xFFFE, ovf=1 (sticky).
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp fields stable, cmd_ready=0 throughout; release -> one handshake, then cmd_ready=1.
- Illegal op 20 -> rsp_err=1, rsp_data=0, controls stay 0. Assert rstn low during MUL A=15 -> no response, all outputs 0, IDLE after release.
